membus_arbiter: RTL
===================

// Module: membus_arbiter
// PURPOSE
//  Shares one Wishbone master port between instruction fetch (IF) and data access (MEM).
//  Sequences each bus cycle and raises per-requester stall requests to ctrl, which maps:
//    stallreq_mem -> stall 6'b011111
//    stallreq_if  -> stall 6'b000111
//  Holds returned data across pipeline stalls and discards results of flushed accesses.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles without wb_ack_i before a bus cycle is force-terminated (1..65535)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   reset, asynchronous, active-high (`RstEnable = 1'b1)
//  stall         in   6   stall vector from ctrl; bit1 = IF stage, bit4 = MEM stage
//  flush         in   1   pipeline flush from ctrl (exception / eret)
//  if_ce         in   1   IF fetch request
//  if_addr       in   32  fetch address
//  if_rdata      out  32  fetched instruction
//  mem_ce        in   1   MEM access request
//  mem_we        in   1   1 = write
//  mem_sel       in   4   byte enables
//  mem_addr      in   32  data address
//  mem_wdata     in   32  write data
//  mem_rdata     out  32  load data
//  stallreq_if   out  1   IF must stall (combinational)
//  stallreq_mem  out  1   MEM must stall (combinational)
//  bus_timeout   out  1   one-cycle pulse when a cycle is terminated by the watchdog
//  wb_adr_o      out  32  Wishbone address
//  wb_dat_o      out  32  write data
//  wb_we_o       out  1   write enable
//  wb_sel_o      out  4   byte select
//  wb_cyc_o      out  1   cycle
//  wb_stb_o      out  1   strobe
//  wb_dat_i      in   32  read data
//  wb_ack_i      in   1   ack
// BEHAVIOUR
//  Reset (async): state=IDLE; all wb_* outputs, rdata buffers, timer and flush_seen = 0.
//    cyc/stb drop immediately, including mid-cycle.
//  States: IDLE, BUSY_D, BUSY_I, HOLD_D, HOLD_I.
//  IDLE:
//   - mem_ce & !flush -> register adr/dat/we/sel, cyc=stb=1, BUSY_D, stallreq_mem=1 same cycle.
//   - else if_ce & !flush -> BUSY_I (we=0, sel=4'hF), stallreq_if=1.
//   - Both requests: MEM wins. IF sees stallreq_if=1 until its own cycle completes.
//   - flush=1 in IDLE: nothing issued that cycle.
//  BUSY_x:
//   - wb outputs held stable, timer increments each cycle.
//   - if_ce=1 while BUSY_D -> stallreq_if=1.
//   - flush during BUSY_x sets flush_seen; the bus cycle is never aborted early.
//  Completion (wb_ack_i=1, or timer==TIMEOUT_CYC-1):
//   - cyc=stb=0 next edge, timer=0.
//   - stallreq_x=0 in the ack cycle; x_rdata = wb_dat_i combinationally (0 on timeout).
//   - Data latched into buffer. Timeout also pulses bus_timeout next cycle.
//   - flush_seen|flush -> IDLE, data discarded (rdata 0).
//   - else D: stall[4]=1 -> HOLD_D, else IDLE. I: stall[1]=1 -> HOLD_I, else IDLE.
//  HOLD_x:
//   - x_rdata = buffer, stallreq_x=0, no new bus cycle (prevents store re-issue).
//   - Leave to IDLE on the edge where the stage bit = 0, or on flush.
//  Outputs: rdata = 0 outside ack/HOLD cycles. stallreq never asserted in HOLD or on reset.
//  Writes: mem_rdata is don't-care, driven 0.
//  Back-to-back: minimum one IDLE cycle between bus cycles.
//  Latency: zero-wait slave acking in the cycle after stb -> 2-cycle access.
// STRUCTURE
//  defines.v additions: state encodings (`ArbIdle .. `ArbHoldI), `IfStallBit=1, `MemStallBit=4.
//  Reuses `RstEnable, `ZeroWord, `RegBus, `Stop.
//  Single module, no sub-module. Timer is a local 16-bit counter.
//  ctrl gains stallreq_from_if / stallreq_from_mem inputs.
// TESTING
//  1. if_ce only, slave acks 1 cycle after stb, data 32'h3402_0001
//     -> stallreq_if 1 for 1 cycle, if_rdata=32'h3402_0001 in ack cycle.
//  2. if_ce & mem_ce same cycle, mem_we=1, addr 32'h10 -> data write issued first;
//     fetch issued after one IDLE cycle; stallreq_if high throughout.
//  3. Load acked while stall=6'b011111 held 3 more cycles -> HOLD_D,
//     mem_rdata stable 3 cycles, exactly one bus cycle.
//  4. flush pulse mid-BUSY_I -> cycle completes on ack, if_rdata=0, IDLE, no re-issue.
//  5. Slave never acks, TIMEOUT_CYC=8 -> cyc drops after 8 cycles,
//     bus_timeout pulses once, rdata=0.
//  6. rst asserted mid-BUSY_D -> cyc/stb/stallreq 0 asynchronously;
//     after release, a new request is issued normally.

Source files
------------

// File: rtl/membus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM Wishbone arbiter.
package membus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_BUSY_D = 3'd1,
        ARB_BUSY_I = 3'd2,
        ARB_HOLD_D = 3'd3,
        ARB_HOLD_I = 3'd4
    } arb_state_e;

    localparam int          IF_STALL_BIT  = 1;
    localparam int          MEM_STALL_BIT = 4;
    localparam logic [31:0] ZERO_WORD     = 32'h0;

    // Registered Wishbone request, held stable for the whole bus cycle
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } wb_req_t;

endpackage

// File: rtl/membus_arbiter_if.sv
// Pipeline-side request/response signals plus the Wishbone master port.
interface membus_arbiter_if;
    logic [5:0]  stall;
    logic        flush;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stallreq_if;
    logic        stallreq_mem;
    logic        bus_timeout;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport slave (
        input  stall, flush, if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
               wb_dat_i, wb_ack_i,
        output if_rdata, mem_rdata, stallreq_if, stallreq_mem, bus_timeout,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o
    );

    modport master (
        output stall, flush, if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr, mem_wdata,
               wb_dat_i, wb_ack_i,
        input  if_rdata, mem_rdata, stallreq_if, stallreq_mem, bus_timeout,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/membus_arbiter.sv
// Shares one Wishbone master between instruction fetch and data access; MEM has priority,
// results are held across pipeline stalls and dropped when the access was flushed.
module membus_arbiter
    import membus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    membus_arbiter_if.slave   bus
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    arb_state_e  r_state, w_next;
    wb_req_t     r_req;
    logic        r_cyc, r_stb;
    logic [15:0] r_timer;
    logic        r_flush_seen, r_timeout;
    logic [31:0] r_dbuf, r_ibuf;

    logic        w_busy, w_done, w_expire, w_drop, w_issue_d, w_issue_i;
    logic [31:0] w_ack_data;

    assign w_busy     = (r_state == ARB_BUSY_D) || (r_state == ARB_BUSY_I);
    assign w_done     = w_busy && (bus.wb_ack_i || (r_timer == TMO_LAST));
    assign w_expire   = w_busy && !bus.wb_ack_i && (r_timer == TMO_LAST);
    assign w_drop     = r_flush_seen || bus.flush;
    assign w_issue_d  = (r_state == ARB_IDLE) && bus.mem_ce && !bus.flush;
    assign w_issue_i  = (r_state == ARB_IDLE) && !bus.mem_ce && bus.if_ce && !bus.flush;
    assign w_ack_data = bus.wb_ack_i ? bus.wb_dat_i : ZERO_WORD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ARB_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_issue_d)      w_next = ARB_BUSY_D;
                else if (w_issue_i) w_next = ARB_BUSY_I;
            end
            ARB_BUSY_D: if (w_done)
                w_next = (!w_drop && bus.stall[MEM_STALL_BIT]) ? ARB_HOLD_D : ARB_IDLE;
            ARB_BUSY_I: if (w_done)
                w_next = (!w_drop && bus.stall[IF_STALL_BIT]) ? ARB_HOLD_I : ARB_IDLE;
            ARB_HOLD_D: if (!bus.stall[MEM_STALL_BIT] || bus.flush) w_next = ARB_IDLE;
            ARB_HOLD_I: if (!bus.stall[IF_STALL_BIT] || bus.flush)  w_next = ARB_IDLE;
            default:    w_next = ARB_IDLE;
        endcase
    end

    // Stall requests and read data are combinational so the pipeline reacts in the ack cycle
    always_comb begin
        bus.stallreq_mem = 1'b0;
        bus.stallreq_if  = 1'b0;
        bus.mem_rdata    = ZERO_WORD;
        bus.if_rdata     = ZERO_WORD;
        case (r_state)
            ARB_IDLE: begin
                bus.stallreq_mem = w_issue_d;
                bus.stallreq_if  = bus.if_ce && !bus.flush;
            end
            ARB_BUSY_D: begin
                bus.stallreq_mem = !w_done;
                bus.stallreq_if  = bus.if_ce;
                if (w_done && !w_drop && !r_req.we) bus.mem_rdata = w_ack_data;
            end
            ARB_BUSY_I: begin
                bus.stallreq_if = bus.if_ce && !w_done;
                if (w_done && !w_drop) bus.if_rdata = w_ack_data;
            end
            ARB_HOLD_D: bus.mem_rdata = r_dbuf;
            ARB_HOLD_I: bus.if_rdata  = r_ibuf;
            default: ;
        endcase
        if (rst) begin
            bus.stallreq_mem = 1'b0;
            bus.stallreq_if  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req        <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_timer      <= 16'h0;
            r_flush_seen <= 1'b0;
            r_timeout    <= 1'b0;
            r_dbuf       <= ZERO_WORD;
            r_ibuf       <= ZERO_WORD;
        end else begin
            r_timeout <= w_expire;
            if (w_issue_d || w_issue_i) begin
                r_req        <= w_issue_d
                              ? wb_req_t'{bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_sel}
                              : wb_req_t'{bus.if_addr, ZERO_WORD, 1'b0, 4'hF};
                r_cyc        <= 1'b1;
                r_stb        <= 1'b1;
                r_timer      <= 16'h0;
                r_flush_seen <= 1'b0;
            end else if (w_done) begin
                r_cyc        <= 1'b0;
                r_stb        <= 1'b0;
                r_timer      <= 16'h0;
                r_flush_seen <= 1'b0;
                if (r_state == ARB_BUSY_D) r_dbuf <= (r_req.we || w_drop) ? ZERO_WORD : w_ack_data;
                else                       r_ibuf <= w_drop ? ZERO_WORD : w_ack_data;
            end else if (w_busy) begin
                r_timer <= r_timer + 16'd1;
                if (bus.flush) r_flush_seen <= 1'b1;
            end
        end
    end

    assign bus.wb_adr_o    = r_req.adr;
    assign bus.wb_dat_o    = r_req.dat;
    assign bus.wb_we_o     = r_req.we;
    assign bus.wb_sel_o    = r_req.sel;
    assign bus.wb_cyc_o    = r_cyc;
    assign bus.wb_stb_o    = r_stb;
    assign bus.bus_timeout = r_timeout;

endmodule
